// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// operand width, funct3 opcodes, FSM state encoding and iteration count.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [XLEN-1:0] neg_if(
        input logic            n,
        input logic [XLEN-1:0] v
    );
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shared 64-bit shift register plus one 34-bit adder; one multiply
// (shift-add) or restoring divide (shift-subtract) step per cycle.
// Ports: clk, rst (sync, active high), load_i (capture operands),
//        step_i (advance one iteration), div_i (mode at load),
//        a_i/b_i (unsigned magnitudes), acc_o (accumulator).
//   multiply: acc_o = a_i * b_i after 32 steps
//   divide:   acc_o = {a_i % b_i, a_i / b_i} after 32 steps
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [63:0]     acc_o
);

    logic [63:0]     acc_q, acc_d;
    logic [XLEN-1:0] op_q, op_d;
    logic            div_q, div_d;

    logic [33:0] add_x;
    logic [33:0] add_y;
    logic [33:0] sum;

    // Divide: x is the partial remainder shifted left with the next
    // dividend bit pulled in, y is the inverted divisor (subtract).
    // Multiply: x is the upper half, y is the multiplicand when the
    // current multiplier LSB is set.
    always_comb begin
        if (div_q) begin
            add_x = {1'b0, acc_q[63:31]};
            add_y = ~{2'b00, op_q};
        end else begin
            add_x = {2'b00, acc_q[63:32]};
            add_y = acc_q[0] ? {2'b00, op_q} : '0;
        end
        sum = add_x + add_y + {33'd0, div_q};
    end

    always_comb begin
        acc_d = acc_q;
        op_d  = op_q;
        div_d = div_q;
        if (load_i) begin
            div_d = div_i;
            op_d  = div_i ? b_i : a_i;
            acc_d = {32'd0, div_i ? a_i : b_i};
        end else if (step_i) begin
            if (div_q) begin
                // Non-negative difference: divisor fits, quotient bit 1.
                if (!sum[33]) begin
                    acc_d = {sum[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {acc_q[62:0], 1'b0};
                end
            end else begin
                acc_d = {sum[32:0], acc_q[31:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            op_q  <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            op_q  <= op_d;
            div_q <= div_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (34-cycle path, bypass for
// divide-by-zero and signed overflow). Optional MULDIV_FAST_MUL_EN:
// single-cycle combinational multiply for all MUL* ops.
// Ports: clk, rst (sync, active high), start, funct3, operandA,
//        operandB, rdIn -> busy, done (1-cycle), result, rdOut.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdOut
);

    state_e state_q, state_d;

    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic [4:0]      rdl_q, rdl_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            is_div;
    logic            a_signed, b_signed;
    logic            sa, sb;
    logic            neg_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
    logic            bypass;
    logic [XLEN-1:0] byp_res;
    logic            core_load;
    logic [63:0]     acc;
    logic [63:0]     prod;
    logic [XLEN-1:0] fix_res;

    // Operand decode, only meaningful in the start cycle.
    assign is_div   = funct3[2];
    assign a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                   || (funct3 == F3_MULHSU) || (funct3 == F3_DIV)
                   || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                   || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sa       = a_signed & operandA[XLEN-1];
    assign sb       = b_signed & operandB[XLEN-1];
    assign mag_a    = neg_if(sa, operandA);
    assign mag_b    = neg_if(sb, operandB);
    // Remainder follows the dividend; everything else the sign product.
    assign neg_in   = (funct3 == F3_REM) ? sa : (sa ^ sb);

    assign div_zero = is_div && (operandB == '0);
    assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                   && (operandA == 32'h8000_0000)
                   && (operandB == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_pa, fast_pb, fast_prod;
    // Low 64 bits of the sign-extended product are exact for all
    // three signedness combinations.
    assign fast_pa   = {{32{sa}}, operandA};
    assign fast_pb   = {{32{sb}}, operandB};
    assign fast_prod = fast_pa * fast_pb;
    assign fast_hit  = ~is_div;
    assign fast_res  = (funct3 == F3_MUL) ? fast_prod[31:0]
                                          : fast_prod[63:32];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = '0;
`endif

    assign bypass = div_zero | div_ovf | fast_hit;

    always_comb begin
        byp_res = fast_res;
        unique case (1'b1)
            div_zero: byp_res = funct3[1] ? operandA : '1;
            div_ovf:  byp_res = funct3[1] ? '0 : 32'h8000_0000;
            default:  byp_res = fast_res;
        endcase
    end

    assign core_load = (state_q == ST_IDLE) && start && !bypass;

    muldiv_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (core_load),
        .step_i (state_q == ST_CALC),
        .div_i  (is_div),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .acc_o  (acc)
    );

    // Sign fix-up and word select on the finished accumulator.
    assign prod = neg_q ? (~acc + 64'd1) : acc;

    always_comb begin
        if (!f3_q[2]) begin
            fix_res = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
        end else if (f3_q[1]) begin
            fix_res = neg_if(neg_q, acc[63:32]);
        end else begin
            fix_res = neg_if(neg_q, acc[31:0]);
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = bypass ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == 5'(ITER_COUNT - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy = (state_q == ST_CALC) || (state_q == ST_FIX);
        done = (state_q == ST_DONE);
    end

    // Datapath bookkeeping; result/rdOut only move on entry to DONE.
    always_comb begin
        cnt_d = cnt_q;
        f3_d  = f3_q;
        neg_d = neg_q;
        rdl_d = rdl_q;
        rd_d  = rd_q;
        res_d = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    f3_d  = funct3;
                    neg_d = neg_in;
                    rdl_d = rdIn;
                    if (bypass) begin
                        res_d = byp_res;
                        rd_d  = rdIn;
                    end
                end
            end
            ST_CALC: cnt_d = cnt_q + 5'd1;
            ST_FIX: begin
                res_d = fix_res;
                rd_d  = rdl_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            rdl_q <= '0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            f3_q  <= f3_d;
            neg_q <= neg_d;
            rdl_q <= rdl_d;
            rd_q  <= rd_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;
    assign rdOut  = rd_q;

endmodule
